// File: rtl/cnt_full_pkg.sv
// Shared async-FIFO pointer helpers: depth from pointer width and binary-to-Gray encoding.
// Used by both the write-side full counter and the read-side empty counter.
package cnt_full_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int fifo_depth(input int width);
    return 1 << (width - 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

endpackage

// File: rtl/cnt_full_gray2bin.sv
// Combinational Gray-to-binary converter; binary bit i is the XOR of Gray bits MSB..i.
module cnt_full_gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/cnt_full.sv
// Write-domain pointer pair and full / level / almost_full / overflow generator for the async FIFO.
// en is a write request; it is accepted only when full is low (inc = en & ~full), otherwise dropped.
module cnt_full
  import cnt_full_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int AFULL_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  input  logic [WIDTH-1:0] cnt_gray_sync,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH-1:0] level,
  output logic             overflow
);

  localparam int             DEPTH    = fifo_depth(WIDTH);
  localparam logic [WIDTH-1:0] AF_LIMIT = WIDTH'(DEPTH - AFULL_TH);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_level;
  logic             r_full;
  logic             r_afull;
  logic             r_ovf;

  logic             w_inc;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic [WIDTH-1:0] w_fp;
  logic [WIDTH-1:0] w_rd_bin;
  logic [WIDTH-1:0] w_level_nxt;
  logic             w_full_nxt;
  logic             w_afull_nxt;

  cnt_full_gray2bin #(.WIDTH(WIDTH)) u_rd_g2b (
    .i_gray (cnt_gray_sync),
    .o_bin  (w_rd_bin)
  );

  assign w_inc       = en & ~r_full;
  assign w_bin_nxt   = r_bin + {{(WIDTH-1){1'b0}}, w_inc};
  assign w_gray_nxt  = WIDTH'(bin2gray(PTR_MAX_W'(w_bin_nxt)));
  // Write pointer is exactly one lap ahead of the read pointer when the top two Gray bits differ.
  assign w_fp        = {~cnt_gray_sync[WIDTH-1:WIDTH-2], cnt_gray_sync[WIDTH-3:0]};
  assign w_full_nxt  = (w_gray_nxt == w_fp);
  assign w_level_nxt = w_bin_nxt - w_rd_bin;
  assign w_afull_nxt = (w_level_nxt >= AF_LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_nxt;
      r_gray  <= w_gray_nxt;
      r_level <= w_level_nxt;
      r_full  <= w_full_nxt;
      r_afull <= w_afull_nxt;
      r_ovf   <= en & r_full;
    end
  end

  assign cnt_bin     = r_bin;
  assign cnt_gray    = r_gray;
  assign level       = r_level;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign overflow    = r_ovf;

endmodule
